// File: rtl/mcpu_pkg.sv
// Shared definitions for the MIPS multi-cycle and single-cycle controllers:
// state codes, ALU operation codes, instruction field constants and ID dispatch.
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MADR   = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_EXR    = 4'd6,
    S_WBR    = 4'd7,
    S_EXBR   = 4'd8,
    S_EXJ    = 4'd9,
    S_EXJAL  = 4'd10,
    S_EXI    = 4'd11,
    S_WBI    = 4'd12,
    S_EXJR   = 4'd13,
    S_EXJALR = 4'd14,
    S_ERR    = 4'd15
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Selector for the ALU decoder: fixed ADD/SUB, R-type Fun field, or I-type opcode.
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUN = 2'b10;
  localparam logic [1:0] ALUOP_IMM = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FUN_ADD  = 6'b100000;
  localparam logic [5:0] FUN_SUB  = 6'b100010;
  localparam logic [5:0] FUN_AND  = 6'b100100;
  localparam logic [5:0] FUN_OR   = 6'b100101;
  localparam logic [5:0] FUN_NOR  = 6'b100111;
  localparam logic [5:0] FUN_SLT  = 6'b101010;
  localparam logic [5:0] FUN_SRL  = 6'b000010;
  localparam logic [5:0] FUN_JR   = 6'b001000;
  localparam logic [5:0] FUN_JALR = 6'b001001;

  localparam logic [1:0] SRCB_RB      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RA     = 2'b11;

  localparam logic [1:0] REGDST_RT    = 2'b00;
  localparam logic [1:0] REGDST_RD    = 2'b01;
  localparam logic [1:0] REGDST_RA31  = 2'b10;

  localparam logic [1:0] WB_ALUOUT    = 2'b00;
  localparam logic [1:0] WB_MDR       = 2'b01;
  localparam logic [1:0] WB_LUI       = 2'b10;
  localparam logic [1:0] WB_PC        = 2'b11;

  // Instruction-class dispatch out of ID; anything unrecognised lands in ERR.
  function automatic state_t id_dispatch(input logic [5:0] opcode, input logic [5:0] fun);
    state_t nxt;
    nxt = S_ERR;
    case (opcode)
      OP_LW, OP_SW:   nxt = S_MADR;
      OP_BEQ, OP_BNE: nxt = S_EXBR;
      OP_J:           nxt = S_EXJ;
      OP_JAL:         nxt = S_EXJAL;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: nxt = S_EXI;
      OP_RTYPE: begin
        case (fun)
          FUN_ADD, FUN_SUB, FUN_AND, FUN_OR,
          FUN_NOR, FUN_SLT, FUN_SRL: nxt = S_EXR;
          FUN_JR:                    nxt = S_EXJR;
          FUN_JALR:                  nxt = S_EXJALR;
          default:                   nxt = S_ERR;
        endcase
      end
      default: nxt = S_ERR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// ALU operation decoder shared by the single-cycle and multi-cycle controllers.
// Unknown Fun/opcode values fall back to ADD; the controllers never select them.
module mcpu_alu_dec
  import mcpu_pkg::*;
#(
  parameter int ALUC_W = 3
) (
  input  logic [1:0]        alu_op,
  input  logic [5:0]        opcode,
  input  logic [5:0]        fun,
  output logic [ALUC_W-1:0] alu_control
);

  logic [2:0] alu_code;

  always_comb begin
    alu_code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_code = ALU_ADD;
      ALUOP_SUB: alu_code = ALU_SUB;
      ALUOP_FUN: begin
        case (fun)
          FUN_ADD: alu_code = ALU_ADD;
          FUN_SUB: alu_code = ALU_SUB;
          FUN_AND: alu_code = ALU_AND;
          FUN_OR:  alu_code = ALU_OR;
          FUN_NOR: alu_code = ALU_NOR;
          FUN_SLT: alu_code = ALU_SLT;
          FUN_SRL: alu_code = ALU_SRL;
          default: alu_code = ALU_ADD;
        endcase
      end
      ALUOP_IMM: begin
        // lui also runs through the adder; its result is discarded at WBI.
        case (opcode)
          OP_ANDI: alu_code = ALU_AND;
          OP_ORI:  alu_code = ALU_OR;
          OP_SLTI: alu_code = ALU_SLT;
          default: alu_code = ALU_ADD;
        endcase
      end
      default: alu_code = ALU_ADD;
    endcase
  end

  assign alu_control = ALUC_W'(alu_code);

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS controller: state register plus wait/timeout counter, with
// control strobes decoded combinationally from state, instruction fields and handshakes.
module mcpu_ctrl
  import mcpu_pkg::*;
#(
  parameter int ALUC_W = 3,
  parameter int TMO_W  = 8,
  parameter int TMO_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        OPcode,
  input  logic [5:0]        Fun,
  input  logic              zero,
  input  logic              MIO_ready,
  output logic              PC_en,
  output logic              IorD,
  output logic              IR_wr,
  output logic              mem_w,
  output logic              CPU_MIO,
  output logic              ALUSrc_A,
  output logic              RegWrite,
  output logic [1:0]        ALUSrc_B,
  output logic [1:0]        PCSource,
  output logic [1:0]        RegDst,
  output logic [1:0]        DatatoReg,
  output logic [ALUC_W-1:0] ALU_Control,
  output logic [3:0]        state,
  output logic              err
);

  state_t             state_reg;
  state_t             state_next;
  logic [TMO_W-1:0]   wait_cnt_reg;

  logic               wait_state;
  logic               wait_sat;
  logic               timeout;

  logic               pc_en_c;
  logic               ir_wr_c;
  logic               mem_w_c;
  logic               cpu_mio_c;
  logic               reg_write_c;
  logic               alu_en;
  logic [1:0]         alu_op;
  logic [ALUC_W-1:0]  alu_dec_out;

  assign wait_state = (state_reg == S_IF) || (state_reg == S_MRD) || (state_reg == S_MWR);
  assign wait_sat   = &wait_cnt_reg;
  assign timeout    = (TMO_EN != 0) && wait_state && !MIO_ready && wait_sat;

  mcpu_alu_dec #(
    .ALUC_W (ALUC_W)
  ) u_alu_dec (
    .alu_op      (alu_op),
    .opcode      (OPcode),
    .fun         (Fun),
    .alu_control (alu_dec_out)
  );

  always_comb begin
    state_next  = state_reg;
    pc_en_c     = 1'b0;
    ir_wr_c     = 1'b0;
    mem_w_c     = 1'b0;
    cpu_mio_c   = 1'b0;
    reg_write_c = 1'b0;
    IorD        = 1'b0;
    ALUSrc_A    = 1'b0;
    ALUSrc_B    = SRCB_RB;
    PCSource    = PCSRC_ALU;
    RegDst      = REGDST_RT;
    DatatoReg   = WB_ALUOUT;
    alu_en      = 1'b0;
    alu_op      = ALUOP_ADD;
    err         = 1'b0;

    case (state_reg)
      S_IF: begin
        cpu_mio_c = 1'b1;
        ALUSrc_B  = SRCB_FOUR;
        alu_en    = 1'b1;
        if (MIO_ready) begin
          ir_wr_c    = 1'b1;
          pc_en_c    = 1'b1;
          state_next = S_ID;
        end
      end
      S_ID: begin
        // Branch target is computed speculatively here and parked in ALUOut.
        ALUSrc_B   = SRCB_IMM_SH2;
        alu_en     = 1'b1;
        state_next = id_dispatch(OPcode, Fun);
      end
      S_MADR: begin
        ALUSrc_A   = 1'b1;
        ALUSrc_B   = SRCB_IMM;
        alu_en     = 1'b1;
        state_next = (OPcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        cpu_mio_c = 1'b1;
        IorD      = 1'b1;
        if (MIO_ready) state_next = S_MWB;
      end
      S_MWB: begin
        reg_write_c = 1'b1;
        DatatoReg   = WB_MDR;
        state_next  = S_IF;
      end
      S_MWR: begin
        cpu_mio_c = 1'b1;
        IorD      = 1'b1;
        mem_w_c   = 1'b1;
        if (MIO_ready) state_next = S_IF;
      end
      S_EXR: begin
        ALUSrc_A   = 1'b1;
        alu_en     = 1'b1;
        alu_op     = ALUOP_FUN;
        state_next = S_WBR;
      end
      S_WBR: begin
        reg_write_c = 1'b1;
        RegDst      = REGDST_RD;
        state_next  = S_IF;
      end
      S_EXBR: begin
        ALUSrc_A   = 1'b1;
        alu_en     = 1'b1;
        alu_op     = ALUOP_SUB;
        PCSource   = PCSRC_ALUOUT;
        pc_en_c    = (OPcode == OP_BNE) ? ~zero : zero;
        state_next = S_IF;
      end
      S_EXJ, S_EXJAL: begin
        PCSource   = PCSRC_JUMP;
        pc_en_c    = 1'b1;
        state_next = S_IF;
        // PC already holds PC+4 here, which is the link value for jal.
        if (state_reg == S_EXJAL) begin
          reg_write_c = 1'b1;
          RegDst      = REGDST_RA31;
          DatatoReg   = WB_PC;
        end
      end
      S_EXJR, S_EXJALR: begin
        PCSource   = PCSRC_RA;
        pc_en_c    = 1'b1;
        state_next = S_IF;
        if (state_reg == S_EXJALR) begin
          reg_write_c = 1'b1;
          RegDst      = REGDST_RD;
          DatatoReg   = WB_PC;
        end
      end
      S_EXI: begin
        ALUSrc_A   = 1'b1;
        ALUSrc_B   = SRCB_IMM;
        alu_en     = 1'b1;
        alu_op     = ALUOP_IMM;
        state_next = S_WBI;
      end
      S_WBI: begin
        reg_write_c = 1'b1;
        DatatoReg   = (OPcode == OP_LUI) ? WB_LUI : WB_ALUOUT;
        state_next  = S_IF;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_next = S_ERR;
      end
    endcase

    // A ready in the final wait cycle still completes the transfer normally.
    if (timeout) state_next = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IF;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Every entry into a wait state is a state change, so clearing on change covers entry.
      if (state_next != state_reg) begin
        wait_cnt_reg <= '0;
      end else if (wait_state && !MIO_ready && !wait_sat) begin
        wait_cnt_reg <= wait_cnt_reg + TMO_W'(1);
      end
    end
  end

  // Strobes that change architectural state or start a bus cycle are held off during reset.
  assign PC_en       = pc_en_c     & rst_n;
  assign IR_wr       = ir_wr_c     & rst_n;
  assign mem_w       = mem_w_c     & rst_n;
  assign CPU_MIO     = cpu_mio_c   & rst_n;
  assign RegWrite    = reg_write_c & rst_n;
  assign ALU_Control = alu_en ? alu_dec_out : '0;
  assign state       = state_reg;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Scoreboard bench for mcpu_ctrl: per-instruction cycle sequences are built from the
// instruction-class rules and queued; a negedge monitor compares every DUT cycle.
module tb_mcpu_ctrl;

  localparam int TB_TMO_W = 2;
  localparam int TMO_LIM  = 1 << TB_TMO_W;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_JR = 3, K_JALR = 4, K_BR = 5,
                 K_J = 6, K_JAL = 7, K_I = 8, K_BAD = 9;

  typedef struct {
    logic [22:0] v;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] OPcode = 6'd0;
  logic [5:0] Fun = 6'd0;
  logic       zero = 1'b0;
  logic       MIO_ready = 1'b0;
  logic       PC_en, IorD, IR_wr, mem_w, CPU_MIO, ALUSrc_A, RegWrite;
  logic [1:0] ALUSrc_B, PCSource, RegDst, DatatoReg;
  logic [2:0] ALU_Control;
  logic [3:0] state;
  logic       err;

  exp_t   q[$];
  exp_t   mon_e;
  int     compared = 0;
  int     mismatched = 0;
  bit     done = 1'b0;
  logic [22:0] got;

  mcpu_ctrl #(
    .ALUC_W (3),
    .TMO_W  (TB_TMO_W),
    .TMO_EN (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .OPcode      (OPcode),
    .Fun         (Fun),
    .zero        (zero),
    .MIO_ready   (MIO_ready),
    .PC_en       (PC_en),
    .IorD        (IorD),
    .IR_wr       (IR_wr),
    .mem_w       (mem_w),
    .CPU_MIO     (CPU_MIO),
    .ALUSrc_A    (ALUSrc_A),
    .RegWrite    (RegWrite),
    .ALUSrc_B    (ALUSrc_B),
    .PCSource    (PCSource),
    .RegDst      (RegDst),
    .DatatoReg   (DatatoReg),
    .ALU_Control (ALU_Control),
    .state       (state),
    .err         (err)
  );

  always #5 clk = ~clk;

  assign got = {state, PC_en, IorD, IR_wr, mem_w, CPU_MIO, ALUSrc_A, RegWrite,
                ALUSrc_B, PCSource, RegDst, DatatoReg, ALU_Control, err};

  // Record layout: state, {PC_en,IorD,IR_wr,mem_w,CPU_MIO,ALUSrc_A,RegWrite}, B, PCSrc, RegDst, DtoR, ALU, err
  function automatic logic [22:0] mk(input logic [3:0] st, input logic [6:0] s,
                                     input logic [1:0] b, input logic [1:0] p,
                                     input logic [1:0] r, input logic [1:0] d,
                                     input logic [2:0] a, input logic e);
    return {st, s, b, p, r, d, a, e};
  endfunction

  function automatic logic [22:0] rst_view(input logic [22:0] v);
    logic [22:0] t;
    t = v;
    t[18] = 1'b0;  // PC_en
    t[16] = 1'b0;  // IR_wr
    t[15] = 1'b0;  // mem_w
    t[14] = 1'b0;  // CPU_MIO
    t[12] = 1'b0;  // RegWrite
    return t;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100, 6'b000101: return K_BR;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111: return K_I;
      6'b000000: begin
        if (fn == 6'b001000) return K_JR;
        if (fn == 6'b001001) return K_JALR;
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                       6'b100111, 6'b101010, 6'b000010}) return K_R;
        return K_BAD;
      end
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      6'b000010: return 3'b101;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b000;
      6'b001101: return 3'b001;
      6'b001010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic cyc(input logic [22:0] v, input string tag, input logic rdy, input logic rstn);
    exp_t x;
    MIO_ready = rdy;
    rst_n     = rstn;
    x.v       = v;
    x.tag     = tag;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic err_and_reset();
    logic [22:0] errv;
    int k;
    errv = mk(4'd15, 7'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
    k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) cyc(errv, "err", rb(), 1'b1);
    cyc(rst_view(errv), "err_rst", rb(), 1'b0);
  endtask

  task automatic wait_phase(input logic [22:0] wv, input logic [22:0] gv, input string tag,
                            input int w, output bit to);
    int n;
    n  = (w >= TMO_LIM) ? TMO_LIM : w;
    to = (w >= TMO_LIM);
    for (int i = 0; i < n; i++) cyc(wv, tag, 1'b0, 1'b1);
    if (!to) cyc(gv, tag, 1'b1, 1'b1);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wif, input int wmem, input bit abort_mwr);
    bit          to;
    int          kind;
    logic        take;
    logic [22:0] madr, mrd, mwr;
    OPcode = op;
    Fun    = fn;
    zero   = z;
    kind   = classify(op, fn);
    madr   = mk(4'd2, 7'b0000010, 2'b10, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0);
    mrd    = mk(4'd3, 7'b0100100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    mwr    = mk(4'd5, 7'b0101100, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    $display("instr op=%b fun=%b zero=%b wif=%0d wmem=%0d kind=%0d abort=%0d",
             op, fn, z, wif, wmem, kind, abort_mwr);
    wait_phase(mk(4'd0, 7'b0000100, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0),
               mk(4'd0, 7'b1010100, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0),
               "if", wif, to);
    if (to) begin
      err_and_reset();
    end else begin
      cyc(mk(4'd1, 7'b0, 2'b11, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0), "id", rb(), 1'b1);
      case (kind)
        K_LW: begin
          cyc(madr, "madr", rb(), 1'b1);
          wait_phase(mrd, mrd, "mrd", wmem, to);
          if (to) err_and_reset();
          else cyc(mk(4'd4, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0), "mwb", rb(), 1'b1);
        end
        K_SW: begin
          cyc(madr, "madr", rb(), 1'b1);
          if (abort_mwr) begin
            cyc(mwr, "mwr", 1'b0, 1'b1);
            cyc(rst_view(mwr), "mwr_rst", 1'b0, 1'b0);
          end else begin
            wait_phase(mwr, mwr, "mwr", wmem, to);
            if (to) err_and_reset();
          end
        end
        K_R: begin
          cyc(mk(4'd6, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, r_alu(fn), 1'b0), "exr", rb(), 1'b1);
          cyc(mk(4'd7, 7'b0000001, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0), "wbr", rb(), 1'b1);
        end
        K_JR:   cyc(mk(4'd13, 7'b1000000, 2'b00, 2'b11, 2'b00, 2'b00, 3'b000, 1'b0), "exjr", rb(), 1'b1);
        K_JALR: cyc(mk(4'd14, 7'b1000001, 2'b00, 2'b11, 2'b01, 2'b11, 3'b000, 1'b0), "exjalr", rb(), 1'b1);
        K_BR: begin
          take = (op == 6'b000100) ? z : ~z;
          cyc(mk(4'd8, {take, 6'b000010}, 2'b00, 2'b01, 2'b00, 2'b00, 3'b110, 1'b0), "exbr", rb(), 1'b1);
        end
        K_J:    cyc(mk(4'd9, 7'b1000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0), "exj", rb(), 1'b1);
        K_JAL:  cyc(mk(4'd10, 7'b1000001, 2'b00, 2'b10, 2'b10, 2'b11, 3'b000, 1'b0), "exjal", rb(), 1'b1);
        K_I: begin
          cyc(mk(4'd11, 7'b0000010, 2'b10, 2'b00, 2'b00, 2'b00, i_alu(op), 1'b0), "exi", rb(), 1'b1);
          cyc(mk(4'd12, 7'b0000001, 2'b00, 2'b00, 2'b00,
                 (op == 6'b001111) ? 2'b10 : 2'b00, 3'b000, 1'b0), "wbi", rb(), 1'b1);
        end
        default: err_and_reset();
      endcase
    end
  endtask

  // Monitor: one comparison per DUT cycle, plus a final drain check.
  always @(negedge clk) begin
    if (done) begin
      compared++;
      if (q.size() != 0) begin
        mismatched++;
        $display("FAIL drain: got %0d pending entries, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end else if (q.size() > 0) begin
      mon_e = q.pop_front();
      compared++;
      if (got !== mon_e.v) begin
        mismatched++;
        $display("FAIL %s: got st=%0d ctl=%b, want st=%0d ctl=%b",
                 mon_e.tag, got[22:19], got[18:0], mon_e.v[22:19], mon_e.v[18:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] vop[19];
    logic [5:0] vfn[19];
    int         idx, wi, wm;
    vop = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
            6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000100, 6'b000101, 6'b000010,
            6'b000011, 6'b001000, 6'b001100, 6'b001101, 6'b001010};
    vfn = '{6'd0, 6'd0, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
            6'b101010, 6'b000010, 6'b001000, 6'b001001, 6'd0, 6'd0, 6'd0,
            6'd0, 6'd0, 6'd0, 6'd0, 6'd0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(rst_view(mk(4'd0, 7'b0000100, 2'b01, 2'b00, 2'b00, 2'b00, 3'b010, 1'b0)), "rst", 1'b0, 1'b0);

    run_instr(6'b001000, 6'b010101, 1'b0, 0, 0, 1'b0);  // addi
    run_instr(6'b100011, 6'b000111, 1'b0, 0, 3, 1'b0);  // lw, 3 wait cycles in MRD
    run_instr(6'b000100, 6'b000000, 1'b1, 1, 0, 1'b0);  // beq taken
    run_instr(6'b000101, 6'b000000, 1'b1, 2, 0, 1'b0);  // bne not taken
    run_instr(6'b000011, 6'b110011, 1'b0, 0, 0, 1'b0);  // jal
    run_instr(6'b001111, 6'b000000, 1'b0, 3, 0, 1'b0);  // lui, longest legal fetch wait
    run_instr(6'b001000, 6'b000000, 1'b0, 4, 0, 1'b0);  // fetch timeout
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);  // illegal opcode
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 0, 1'b1);  // reset mid-MWR
    run_instr(6'b000000, 6'b111111, 1'b0, 0, 0, 1'b0);  // illegal Fun
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 4, 1'b0);  // store timeout

    for (int n = 0; n < 250; n++) begin
      wi = ($urandom_range(0, 29) == 0) ? TMO_LIM + $urandom_range(0, 1) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 19) == 0) ? TMO_LIM + $urandom_range(0, 1) : $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) begin
        run_instr(6'($urandom), 6'($urandom), rb(), wi, wm, 1'b0);
      end else begin
        idx = $urandom_range(0, 18);
        run_instr(vop[idx], (vop[idx] == 6'b000000) ? vfn[idx] : 6'($urandom), rb(), wi, wm,
                  (vop[idx] == 6'b101011) && ($urandom_range(0, 24) == 0));
      end
    end

    done = 1'b1;
  end

endmodule

// File: doc/mcpu_ctrl.md
MCPU_CTRL -- requirements
Module: mcpu_ctrl

Interface
REQ-001 Parameter ALUC_W, default 3, ALU_Control width; encodings: AND=000, OR=001, ADD=010, NOR=100, SRL=101, SUB=110, SLT=111.
REQ-002 Parameter TMO_W, default 8, width of the memory-wait timeout counter.
REQ-003 Parameter TMO_EN, default 1, 1 enables the memory timeout; 0 waits forever.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 OPcode  in  6  IR[31:26], held stable by the datapath from ID until the next IF.
REQ-007 Fun  in  6  IR[5:0], same stability as OPcode.
REQ-008 zero  in  1  ALU zero flag, valid in EX_BR.
REQ-009 MIO_ready  in  1  memory/IO transfer complete this cycle.
REQ-010 PC_en, IorD, IR_wr, mem_w, CPU_MIO, ALUSrc_A, RegWrite  out  1 each  PC write, address select (0=PC), IR load, memory write, memory request, ALU A select (0=PC), register-file write.
REQ-011 ALUSrc_B, PCSource, RegDst, DatatoReg  out  2 each  B: 00=rB, 01=4, 10=sext imm, 11=sext imm<<2; PCSource: 00=ALU, 01=ALUOut, 10=jump target, 11=rA; RegDst: 00=rt, 01=rd, 10=$31; DatatoReg: 00=ALUOut, 01=MDR, 10=lui imm, 11=PC.
REQ-012 ALU_Control  out  ALUC_W  ALU operation.
REQ-013 state  out  4  current state, debug.
REQ-014 err  out  1  sticky error flag.

Function
REQ-015 States SHALL be encoded: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, EXR=6, WBR=7, EXBR=8, EXJ=9, EXJAL=10, EXI=11, WBI=12, EXJR=13, EXJALR=14, ERR=15.
REQ-016 IF: CPU_MIO=1, IorD=0, ALUSrc_A=0, ALUSrc_B=01, ALU ADD, PCSource=00. On MIO_ready=1: IR_wr=1, PC_en=1, next ID. Otherwise stay, all writes 0.
REQ-017 ID: ALUSrc_A=0, ALUSrc_B=11, ALU ADD (branch target into ALUOut). Dispatch: lw(100011)/sw(101011)->MADR; R-type(000000) with Fun in {100000,100010,100100,100101,100111,101010,000010}->EXR; Fun 001000->EXJR; Fun 001001->EXJALR; beq(000100)/bne(000101)->EXBR; j(000010)->EXJ; jal(000011)->EXJAL; addi(001000)/andi(001100)/ori(001101)/slti(001010)/lui(001111)->EXI. Any other OPcode/Fun->ERR.
REQ-018 MADR: ALUSrc_A=1, ALUSrc_B=10, ADD; next MRD for lw, MWR for sw.
REQ-019 MRD: CPU_MIO=1, IorD=1; wait for MIO_ready, then MWB. MWB: RegWrite=1, RegDst=00, DatatoReg=01; next IF.
REQ-020 MWR: CPU_MIO=1, IorD=1, mem_w=1 while waiting; on MIO_ready next IF.
REQ-021 EXR: ALUSrc_A=1, ALUSrc_B=00, ALU_Control decoded from Fun (add ADD, sub SUB, and AND, or OR, nor NOR, slt SLT, srl SRL); next WBR. WBR: RegWrite=1, RegDst=01, DatatoReg=00; next IF.
REQ-022 EXBR: ALUSrc_A=1, ALUSrc_B=00, SUB, PCSource=01; PC_en = zero for beq, ~zero for bne; next IF.
REQ-023 EXJ: PCSource=10, PC_en=1; next IF. EXJAL: additionally RegWrite=1, RegDst=10, DatatoReg=11 (PC+4 already in PC); next IF.
REQ-024 EXJR: PCSource=11, PC_en=1; next IF. EXJALR: as EXJR plus RegWrite=1, RegDst=01, DatatoReg=11; next IF.
REQ-025 EXI: ALUSrc_A=1, ALUSrc_B=10; ALU ADD/AND/OR/SLT for addi/andi/ori/slti, ADD for lui; next WBI. WBI: RegWrite=1, RegDst=00, DatatoReg=10 for lui else 00; next IF.
REQ-026 Wait counter SHALL clear on entry to IF/MRD/MWR, increment each cycle MIO_ready=0 in those states, saturate at all-ones.
REQ-027 With TMO_EN=1, a wait cycle with counter all-ones and MIO_ready=0 SHALL go to ERR; MIO_ready=1 in that same cycle wins (normal transition).
REQ-028 ERR: err=1, all write strobes and CPU_MIO 0; exits only by reset.
REQ-029 Outputs not listed for a state SHALL be 0; all outputs combinational from state, OPcode, Fun, zero, MIO_ready.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force state=IF, counter=0, err=0, regardless of current state including mid-wait and ERR.
REQ-031 During reset cycles PC_en, IR_wr, mem_w, RegWrite, CPU_MIO SHALL be 0.

Structure
REQ-032 State encodings, ALU_Control encodings, OPcode and Fun constants SHALL live in shared package mcpu_pkg.
REQ-033 One sub-module, mcpu_alu_dec (Fun/OPcode -> ALU_Control), shared with the single-cycle controller.

Verification
REQ-034 addi, MIO_ready=1 always -> states 0,1,11,12,0; RegWrite=1 only in WBI, ALU_Control=010.
REQ-035 lw with MIO_ready low 3 cycles in MRD -> MRD held 4 cycles, then MWB with DatatoReg=01, RegWrite=1.
REQ-036 beq zero=1 -> PC_en=1, PCSource=01 in EXBR; bne zero=1 -> PC_en=0.
REQ-037 jal -> EXJAL with RegDst=10, DatatoReg=11, PCSource=10, PC_en=1 in one cycle.
REQ-038 TMO_W=2, MIO_ready held 0 in IF -> ERR after 4 wait cycles, err=1; rst_n=0 one edge -> state=0, err=0.
REQ-039 OPcode 111111 -> ID then ERR; reset asserted mid-MWR -> IF next edge, mem_w=0.
